// File: rtl/first_layer_delta_gen.sv
// first_layer_delta_gen
//   Backward-pass delta producer for one first-layer hidden neuron.
//   The error is gated by the ReLU derivative and scaled by 2^-LR_SHIFT with
//   saturation. One delta_weight is streamed per image pixel, and delta_bias
//   is also produced.
//   Optional feature macro: FIRST_DELTA_ZERO_SKIP_EN. When it is defined and
//   the scaled delta is zero, the burst is skipped and the block goes
//   straight to DONE.
//
//   Handshake: start_state5 is accepted only in IDLE. While busy, and in the
//   DONE cycle, it is ignored. delta_valid qualifies delta_weight for exactly
//   one cycle per pixel, with no back-pressure. update_first_layer flags the
//   first valid delta. end_state5 flags completion one cycle after the last
//   delta.
module first_layer_delta_gen #(
    parameter int NWBITS     = 16,
    parameter int NPIXEL     = 784,
    parameter int COUNT_BIT1 = 10,
    parameter int LR_SHIFT   = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start_state5,
    input  logic signed [NWBITS+COUNT_BIT1-1:0]  hidden_neuron,
    input  logic signed [NWBITS+COUNT_BIT1-1:0]  back_error,
    output logic        [COUNT_BIT1-1:0]         pixel_addr,
    input  logic                                 pixel_data,
    output logic                                 update_first_layer,
    output logic signed [NWBITS-1:0]             delta_weight,
    output logic signed [NWBITS-1:0]             delta_bias,
    output logic                                 delta_valid,
    output logic                                 busy,
    output logic                                 end_state5,
    output logic        [2:0]                    state_dbg
);

    localparam int GW = NWBITS + COUNT_BIT1;
    localparam int CW = COUNT_BIT1 + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CALC   = 3'd1;
    localparam logic [2:0] FETCH  = 3'd2;
    localparam logic [2:0] STREAM = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    // Symmetric saturation bounds, so negating the result can never overflow.
    localparam logic signed [GW-1:0] SAT_MAX = GW'((1 << (NWBITS - 1)) - 1);
    localparam logic signed [GW-1:0] SAT_MIN = -SAT_MAX;

    localparam logic [CW-1:0]         NPIX_C     = CW'(NPIXEL);
    localparam logic [CW-1:0]         LAST_ADDR  = CW'(NPIXEL - 1);
    localparam logic [COUNT_BIT1-1:0] FIRST_ADDR = (NPIXEL > 1) ? COUNT_BIT1'(1) : '0;

    logic [2:0]               state;
    logic signed [GW-1:0]     g_reg;
    logic signed [NWBITS-1:0] mag;
    // Index of the pixel whose data is on pixel_data during this cycle.
    logic [CW-1:0]            cnt;

    logic signed [GW-1:0]     scaled_full;
    logic signed [NWBITS-1:0] scaled_sat;
    logic signed [NWBITS-1:0] neg_sat;
    logic [CW-1:0]            addr_ahead;
    logic [CW-1:0]            addr_next;

    assign state_dbg = state;

    // Scale the gated error by the learning rate, then clamp it to the symmetric range.
    always_comb begin
        scaled_full = g_reg >>> LR_SHIFT;
        scaled_sat  = '0;
        if (scaled_full > SAT_MAX) begin
            scaled_sat = SAT_MAX[NWBITS-1:0];
        end else if (scaled_full < SAT_MIN) begin
            scaled_sat = SAT_MIN[NWBITS-1:0];
        end else begin
            scaled_sat = scaled_full[NWBITS-1:0];
        end
        neg_sat = -scaled_sat;
    end

    // The read address runs two pixels ahead of the data index. It is clamped at the last pixel.
    always_comb begin
        addr_ahead = cnt + CW'(2);
        addr_next  = (addr_ahead > LAST_ADDR) ? LAST_ADDR : addr_ahead;
    end

    // Control FSM plus the registered delta/address outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            g_reg              <= '0;
            mag                <= '0;
            cnt                <= '0;
            pixel_addr         <= '0;
            update_first_layer <= 1'b0;
            delta_weight       <= '0;
            delta_bias         <= '0;
            delta_valid        <= 1'b0;
            busy               <= 1'b0;
            end_state5         <= 1'b0;
        end else begin
            update_first_layer <= 1'b0;
            end_state5         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_state5) begin
                        g_reg      <= (hidden_neuron > 0) ? back_error : '0;
                        cnt        <= '0;
                        pixel_addr <= '0;
                        busy       <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    mag <= neg_sat;
`ifdef FIRST_DELTA_ZERO_SKIP_EN
                    if (neg_sat == '0) begin
                        end_state5 <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end else begin
                        pixel_addr <= FIRST_ADDR;
                        state      <= FETCH;
                    end
`else
                    pixel_addr <= FIRST_ADDR;
                    state      <= FETCH;
`endif
                end
                FETCH: begin
                    // Pixel 0 data is present, so emit the first delta and the bias.
                    delta_weight       <= pixel_data ? mag : '0;
                    delta_valid        <= 1'b1;
                    update_first_layer <= 1'b1;
                    delta_bias         <= mag;
                    pixel_addr         <= addr_next[COUNT_BIT1-1:0];
                    cnt                <= cnt + CW'(1);
                    state              <= STREAM;
                end
                STREAM: begin
                    if (cnt < NPIX_C) begin
                        delta_weight <= pixel_data ? mag : '0;
                        delta_valid  <= 1'b1;
                        pixel_addr   <= addr_next[COUNT_BIT1-1:0];
                        cnt          <= cnt + CW'(1);
                    end else begin
                        delta_weight <= '0;
                        delta_valid  <= 1'b0;
                        pixel_addr   <= '0;
                        cnt          <= '0;
                        end_state5   <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
